video_src_switch: RTL and testbench



---
 rtl/video_pkg.sv | 25 ++
 rtl/video_delay_line.sv | 37 +++
 rtl/video_src_switch.sv | 173 +++++++++++++++++
 tb/tb_video_src_switch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video source switch: fvht bit positions,
// black-level helpers and the switch FSM state encoding.
package video_pkg;

    localparam int FVHT_F   = 3;
    localparam int FVHT_V   = 2;
    localparam int FVHT_H   = 1;
    localparam int FVHT_TRS = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARMED = 2'd1,
        ST_MUTE  = 2'd2
    } sw_state_e;

    // Studio-range black scaled from the 8-bit values 16/128 (64/512 at DW=10); DW >= 8.
    function automatic int black_luma(input int dw);
        return 16 << (dw - 8);
    endfunction

    function automatic int black_chroma(input int dw);
        return 128 << (dw - 8);
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Clock-enable qualified shift register with synchronous reset; DEPTH = 0
// degenerates to a wire.
module video_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cen_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_reg [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_reg[i] <= '0;
                    end
                end else if (cen_i) begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_src_switch.sv
// N-input video selector that only changes source at the vertical-blanking edge,
// optionally muting active video afterwards. Define VIDEO_SRC_SWITCH_CHKSUM_EN for the output luma checksum.
module video_src_switch
    import video_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DW          = 10,
    parameter int PIPE        = 2,
    parameter int MUTE_FRAMES = 1,
    parameter int SEL_W       = $clog2(NUM_SRC)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cen_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [NUM_SRC*2*DW-1:0]   vdat_i,
    input  logic [3:0]                fvht_i,
    output logic [2*DW-1:0]           video_o,
    output logic [3:0]                fvht_o,
    output logic [SEL_W-1:0]          active_sel_o,
    output logic                      busy_o,
    output logic                      sel_err_o
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
    ,
    output logic [15:0]               chksum_o,
    output logic                      chksum_vld_o
`endif
);

    localparam int SMP_W = 2 * DW;
    localparam int CNT_W = (MUTE_FRAMES > 0) ? $clog2(MUTE_FRAMES + 1) : 1;
    localparam logic [DW-1:0]    BLACK_Y = DW'(black_luma(DW));
    localparam logic [DW-1:0]    BLACK_C = DW'(black_chroma(DW));
    localparam logic [SMP_W-1:0] BLACK   = {BLACK_Y, BLACK_C};

    sw_state_e          state_reg;
    logic [SEL_W-1:0]   active_sel_reg;
    logic [SEL_W-1:0]   pending_reg;
    logic [CNT_W-1:0]   mute_cnt_reg;
    logic               vs_prev_reg;
    logic               sel_err_reg;
    logic [SMP_W+3:0]   stage0_reg;
    logic [SMP_W+3:0]   pipe_out;
    logic [SMP_W-1:0]   mux_data;
    logic               vs_rise;
    logic               sample_active;
    logic               sel_valid;

    // Unused select codes above NUM_SRC read as zero so the mux index never leaves the array.
    logic [SMP_W-1:0] src_arr [2**SEL_W];
    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_src
            if (gi < NUM_SRC) begin : g_real
                assign src_arr[gi] = vdat_i[gi*SMP_W +: SMP_W];
            end else begin : g_pad
                assign src_arr[gi] = '0;
            end
        end
    endgenerate

    assign vs_rise       = fvht_i[FVHT_V] & ~vs_prev_reg;
    assign sample_active = ~fvht_i[FVHT_V] & ~fvht_i[FVHT_H];
    assign sel_valid     = (int'(sel_i) < NUM_SRC);

    always_comb begin
        mux_data = src_arr[active_sel_reg];
        if (state_reg == ST_MUTE && sample_active) begin
            mux_data = BLACK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_RUN;
            active_sel_reg <= '0;
            pending_reg    <= '0;
            mute_cnt_reg   <= '0;
            vs_prev_reg    <= 1'b0;
            sel_err_reg    <= 1'b0;
            stage0_reg     <= '0;
        end else if (cen_i) begin
            vs_prev_reg <= fvht_i[FVHT_V];
            stage0_reg  <= {fvht_i, mux_data};
            if (!sel_valid) begin
                sel_err_reg <= 1'b1;
            end
            case (state_reg)
                ST_RUN: begin
                    if (sel_valid && sel_i != active_sel_reg) begin
                        pending_reg <= sel_i;
                        state_reg   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // The boundary wins over a same-cycle select change; that change re-arms later.
                    if (vs_rise) begin
                        active_sel_reg <= pending_reg;
                        if (MUTE_FRAMES > 0) begin
                            mute_cnt_reg <= CNT_W'(MUTE_FRAMES);
                            state_reg    <= ST_MUTE;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end else if (sel_valid) begin
                        if (sel_i == active_sel_reg) begin
                            state_reg <= ST_RUN;
                        end else begin
                            pending_reg <= sel_i;
                        end
                    end
                end
                ST_MUTE: begin
                    if (vs_rise) begin
                        if (mute_cnt_reg <= CNT_W'(1)) begin
                            mute_cnt_reg <= '0;
                            if (sel_valid && sel_i != active_sel_reg) begin
                                pending_reg <= sel_i;
                                state_reg   <= ST_ARMED;
                            end else begin
                                state_reg <= ST_RUN;
                            end
                        end else begin
                            mute_cnt_reg <= mute_cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    video_delay_line #(
        .WIDTH (SMP_W + 4),
        .DEPTH (PIPE - 1)
    ) u_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cen_i (cen_i),
        .din   (stage0_reg),
        .dout  (pipe_out)
    );

    assign fvht_o       = pipe_out[SMP_W +: 4];
    assign video_o      = pipe_out[SMP_W-1:0];
    assign active_sel_o = active_sel_reg;
    assign busy_o       = (state_reg != ST_RUN);
    assign sel_err_o    = sel_err_reg;

`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
    logic [15:0] chk_acc_reg;
    logic        chk_vs_prev_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chk_acc_reg     <= '0;
            chk_vs_prev_reg <= 1'b0;
            chksum_o        <= '0;
            chksum_vld_o    <= 1'b0;
        end else if (cen_i) begin
            chk_vs_prev_reg <= fvht_o[FVHT_V];
            chksum_vld_o    <= 1'b0;
            if (fvht_o[FVHT_V] && !chk_vs_prev_reg) begin
                chksum_o     <= chk_acc_reg;
                chk_acc_reg  <= '0;
                chksum_vld_o <= 1'b1;
            end else if (!fvht_o[FVHT_V] && !fvht_o[FVHT_H]) begin
                chk_acc_reg <= chk_acc_reg + 16'(video_o[2*DW-1:DW]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_video_src_switch.sv
// Scoreboard bench for video_src_switch: a 4-source muting instance and a
// 3-source no-mute instance share timing, driven by small directed frames.
module tb_video_src_switch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic [1:0]  sel_a = '0;
    logic [1:0]  sel_b = '0;
    logic [79:0] vdat = '0;
    logic [3:0]  fvht = '0;

    logic [19:0] video_a, video_b;
    logic [3:0]  fvht_a, fvht_b;
    logic [1:0]  act_a, act_b;
    logic        busy_a, busy_b, err_a, err_b;
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
    logic [15:0] chk_a, chk_b;
    logic        chk_vld_a, chk_vld_b;
`endif

    always #5 clk = ~clk;

    video_src_switch #(.NUM_SRC(4), .DW(10), .PIPE(2), .MUTE_FRAMES(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .sel_i(sel_a), .vdat_i(vdat), .fvht_i(fvht),
        .video_o(video_a), .fvht_o(fvht_a), .active_sel_o(act_a), .busy_o(busy_a), .sel_err_o(err_a)
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
        , .chksum_o(chk_a), .chksum_vld_o(chk_vld_a)
`endif
    );

    video_src_switch #(.NUM_SRC(3), .DW(10), .PIPE(2), .MUTE_FRAMES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .sel_i(sel_b), .vdat_i(vdat[59:0]), .fvht_i(fvht),
        .video_o(video_b), .fvht_o(fvht_b), .active_sel_o(act_b), .busy_o(busy_b), .sel_err_o(err_b)
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
        , .chksum_o(chk_b), .chksum_vld_o(chk_vld_b)
`endif
    );

    int checks = 0;
    int errors = 0;
    int smp = 0;
    int frame_no = 0;
    int b_sel = 0;
    bit cen_toggle = 0;
    bit mon_en = 0;
    bit en_q = 0;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];
    logic [23:0] last_a = '0;
    logic [23:0] last_b = '0;
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
    logic [15:0] m_acc = '0;
    logic [15:0] m_chk = '0;
    bit m_vld = 0;
    bit m_prev = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] srcval(input int k, input int idx);
        logic [19:0] b;
        case (k)
            0:       b = 20'h0A0B0;
            1:       b = 20'h13579;
            2:       b = 20'h2A155;
            default: b = 20'h3C0F3;
        endcase
        return b ^ {12'h0, 8'(idx)};
    endfunction

    always @(posedge clk) en_q <= cen && !rst;

    // Monitor: each enabled edge retires one expected sample; disabled edges must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (en_q) begin
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
                if (last_a[22] && !m_prev) begin
                    m_chk = m_acc;
                    m_acc = '0;
                    m_vld = 1;
                end else begin
                    m_vld = 0;
                    if (!last_a[22] && !last_a[21]) m_acc = m_acc + 16'(last_a[19:10]);
                end
                m_prev = last_a[22];
`endif
                if (q_a.size() == 0) chk("queue_a_underflow", 32'd1, 32'd0);
                else last_a = q_a.pop_front();
                if (q_b.size() == 0) chk("queue_b_underflow", 32'd1, 32'd0);
                else last_b = q_b.pop_front();
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
                chk("chksum_vld", 32'(chk_vld_a), 32'(m_vld));
                if (m_vld) chk("chksum", 32'(chk_a), 32'(m_chk));
`endif
            end
            chk("stream_a", {8'h0, fvht_a, video_a}, {8'h0, last_a});
            chk("stream_b", {8'h0, fvht_b, video_b}, {8'h0, last_b});
        end
    end

    task automatic drive(input logic [3:0] fv, input int sa, input int a_src, input bit a_mute, input int b_src);
        logic [19:0] ea;
        if (cen_toggle) begin
            @(negedge clk); #1;
            cen  = 1'b0;
            fvht = 4'($urandom);
            vdat = 80'({$urandom, $urandom, $urandom});
        end
        @(negedge clk); #1;
        cen   = 1'b1;
        fvht  = fv;
        sel_a = 2'(sa);
        sel_b = 2'(b_sel);
        for (int k = 0; k < 4; k++) vdat[k*20 +: 20] = srcval(k, smp);
        ea = (a_mute && !fv[2] && !fv[1]) ? 20'h10200 : srcval(a_src, smp);
        q_a.push_back({fv, ea});
        q_b.push_back({fv, srcval(b_src, smp)});
        smp++;
    endtask

    // 20-sample frame: 4 vblank samples, then 2 lines of 2 hblank + 6 active.
    task automatic run_frame(input int a_pre, input int a_post, input bit a_mute,
                             input int c1p, input int c1v, input int c2p, input int c2v,
                             input int b_pre, input int b_post);
        int sa;
        int col;
        logic [3:0] fv;
        logic fb;
        sa = int'(sel_a);
        fb = frame_no[0];
        for (int p = 0; p < 20; p++) begin
            if (p == c1p) sa = c1v;
            if (p == c2p) sa = c2v;
            if (p < 4) begin
                fv = {fb, 1'b1, 1'b0, (p == 0)};
            end else begin
                col = (p - 4) % 8;
                fv = (col < 2) ? {fb, 2'b01, (col == 0)} : {fb, 3'b000};
            end
            drive(fv, sa, (p == 0) ? a_pre : a_post, (p == 0) ? 1'b0 : a_mute,
                  (p == 0) ? b_pre : b_post);
        end
        frame_no++;
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(negedge clk); #1;
        rst   = 1'b1;
        cen   = 1'b1;
        fvht  = 4'hF;
        vdat  = 80'({$urandom, $urandom, $urandom});
        sel_a = 2'd0;
        b_sel = 0;
        sel_b = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_video_a", 32'(video_a), 32'd0);
        chk("rst_fvht_a", 32'(fvht_a), 32'd0);
        chk("rst_active_a", 32'(act_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_err_a", 32'(err_a), 32'd0);
        chk("rst_video_b", 32'(video_b), 32'd0);
        chk("rst_err_b", 32'(err_b), 32'd0);
        rst = 1'b0;
        cen = 1'b0;
        q_a.delete();
        q_b.delete();
        q_a.push_back('0);
        q_b.push_back('0);
        last_a = '0;
        last_b = '0;
`ifdef VIDEO_SRC_SWITCH_CHKSUM_EN
        m_acc = '0; m_chk = '0; m_vld = 0; m_prev = 0;
`endif
        mon_en = 1;
    endtask

    initial begin
        do_reset();
        // B sees an out-of-range select while A idles on source 0.
        b_sel = 3;
        run_frame(0, 0, 0, -1, 0, -1, 0, 0, 0);
        chk("b_sel_err", 32'(err_b), 32'd1);
        chk("b_active_unchanged", 32'(act_b), 32'd0);
        chk("b_busy_after_invalid", 32'(busy_b), 32'd0);
        chk("a_no_sel_err", 32'(err_a), 32'd0);
        b_sel = 2;
        // A: 0 -> 3 requested mid-frame, muted frame, then source 3.
        run_frame(0, 0, 0, 8, 3, -1, 0, 0, 0);
        chk("a_busy_armed", 32'(busy_a), 32'd1);
        chk("a_active_before_vs", 32'(act_a), 32'd0);
        chk("b_busy_armed", 32'(busy_b), 32'd1);
        run_frame(0, 3, 1, -1, 0, -1, 0, 0, 2);
        chk("a_active_switched", 32'(act_a), 32'd3);
        chk("a_busy_mute", 32'(busy_a), 32'd1);
        chk("b_active_switched", 32'(act_b), 32'd2);
        chk("b_busy_nomute", 32'(busy_b), 32'd0);
        run_frame(3, 3, 0, -1, 0, -1, 0, 2, 2);
        chk("a_busy_after_mute", 32'(busy_a), 32'd0);
        // Last request wins, with the clock enable toggling.
        cen_toggle = 1;
        run_frame(3, 3, 0, 6, 1, 12, 0, 2, 2);
        chk("a_busy_lastwins", 32'(busy_a), 32'd1);
        run_frame(3, 0, 1, -1, 0, -1, 0, 2, 2);
        chk("a_active_lastwins", 32'(act_a), 32'd0);
        run_frame(0, 0, 0, -1, 0, -1, 0, 2, 2);
        chk("a_busy_lastwins_done", 32'(busy_a), 32'd0);
        cen_toggle = 0;
        // Cancel by reselecting the active source.
        run_frame(0, 0, 0, 8, 2, 14, 0, 2, 2);
        chk("a_busy_cancel", 32'(busy_a), 32'd0);
        run_frame(0, 0, 0, -1, 0, -1, 0, 2, 2);
        chk("a_active_cancel", 32'(act_a), 32'd0);
        // Request arriving during mute re-arms when the mute ends.
        run_frame(0, 0, 0, 8, 1, -1, 0, 2, 2);
        run_frame(0, 1, 1, 10, 2, -1, 0, 2, 2);
        chk("a_active_one", 32'(act_a), 32'd1);
        run_frame(1, 1, 0, -1, 0, -1, 0, 2, 2);
        chk("a_rearm_after_mute", 32'(busy_a), 32'd1);
        run_frame(1, 2, 1, -1, 0, -1, 0, 2, 2);
        run_frame(2, 2, 0, -1, 0, -1, 0, 2, 2);
        chk("a_active_two", 32'(act_a), 32'd2);
        chk("a_busy_two_done", 32'(busy_a), 32'd0);
        // Select change on the boundary sample itself: the switch uses the older pending value.
        run_frame(2, 2, 0, 10, 3, -1, 0, 2, 2);
        run_frame(2, 3, 1, 0, 1, -1, 0, 2, 2);
        chk("a_simul_uses_old", 32'(act_a), 32'd3);
        run_frame(3, 3, 0, -1, 0, -1, 0, 2, 2);
        chk("a_simul_rearmed", 32'(busy_a), 32'd1);
        run_frame(3, 1, 1, -1, 0, -1, 0, 2, 2);
        chk("a_active_simul_final", 32'(act_a), 32'd1);
        run_frame(1, 1, 0, -1, 0, -1, 0, 2, 2);
        chk("a_busy_simul_done", 32'(busy_a), 32'd0);
        // Reset while armed abandons the request; no black frame follows.
        run_frame(1, 1, 0, 8, 2, -1, 0, 2, 2);
        chk("a_busy_before_rst", 32'(busy_a), 32'd1);
        do_reset();
        chk("a_active_after_rst", 32'(act_a), 32'd0);
        chk("a_busy_after_rst", 32'(busy_a), 32'd0);
        run_frame(0, 0, 0, -1, 0, -1, 0, 0, 0);
        run_frame(0, 0, 0, -1, 0, -1, 0, 0, 0);
        chk("a_active_final", 32'(act_a), 32'd0);
        @(negedge clk); #1;
        cen = 1'b0;
        @(negedge clk); #1;
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
